// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
package stopwatch_pkg;

  localparam int MS_W  = 10;
  localparam int SEC_W = 6;

  localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

endpackage

// File: rtl/edge_detect.sv
// 1-bit rising-edge detector: rise is high for the cycle in which din is 1
// and was 0 on the previous clock.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev;

  // History register holding last cycle's level.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) prev <= 1'b0;
    else       prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM and min/sec/ms accumulator with lap-freeze display.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 100,
  parameter int MIN_W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_clear,
  input  logic             btn_lap,
  input  logic             msclock,
  output logic             pg_start,
  output logic             pg_stop,
  output logic             pg_reset,
  output logic [MIN_W-1:0] disp_min,
  output logic [SEC_W-1:0] disp_sec,
  output logic [MS_W-1:0]  disp_ms,
  output logic             running,
  output logic             lap_frozen,
  output logic             ovf
);

  logic ev_start, ev_stop, ev_clear, ev_lap, ev_tick;

  edge_detect u_ed_start (.clk(clk), .reset(reset), .din(btn_start), .rise(ev_start));
  edge_detect u_ed_stop  (.clk(clk), .reset(reset), .din(btn_stop),  .rise(ev_stop));
  edge_detect u_ed_clear (.clk(clk), .reset(reset), .din(btn_clear), .rise(ev_clear));
  edge_detect u_ed_lap   (.clk(clk), .reset(reset), .din(btn_lap),   .rise(ev_lap));
  edge_detect u_ed_tick  (.clk(clk), .reset(reset), .din(msclock),   .rise(ev_tick));

  state_t             state_q, state_d;
  logic [MIN_W-1:0]   min_q, min_d, lap_min_q, lap_min_d;
  logic [SEC_W-1:0]   sec_q, sec_d, lap_sec_q, lap_sec_d;
  logic [MS_W-1:0]    ms_q,  ms_d,  lap_ms_q,  lap_ms_d;
  logic               ovf_q, ovf_d;
  logic               pg_start_q;
  logic               pg_stop_c, pg_reset_c;
  logic               counting, at_max, saturate;

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign at_max   = (min_q == MIN_W'(MAX_MIN - 1)) && (sec_q == SEC_MAX) && (ms_q == MS_MAX);
  assign saturate = counting && ev_tick && at_max;

  // Next-state, counter update and pulse generation.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d    = state_q;
    min_d      = min_q;
    sec_d      = sec_q;
    ms_d       = ms_q;
    lap_min_d  = lap_min_q;
    lap_sec_d  = lap_sec_q;
    lap_ms_d   = lap_ms_q;
    ovf_d      = ovf_q;
    pg_stop_c  = 1'b0;
    pg_reset_c = 1'b0;

    // Tick accumulation with ms->sec->min rollover; the saturating tick is dropped.
    if (counting && ev_tick && !at_max) begin
      if (ms_q == MS_MAX) begin
        ms_d = '0;
        if (sec_q == SEC_MAX) begin
          sec_d = '0;
          min_d = min_q + MIN_W'(1);
        end else begin
          sec_d = sec_q + SEC_W'(1);
        end
      end else begin
        ms_d = ms_q + MS_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (ev_start) begin
          state_d    = RUN;
          pg_reset_c = 1'b1;
        end
      end
      RUN, LAP: begin
        if (ev_clear) begin
          state_d    = IDLE;
          min_d      = '0;
          sec_d      = '0;
          ms_d       = '0;
          ovf_d      = 1'b0;
          pg_reset_c = 1'b1;
        end else if (ev_stop || saturate) begin
          state_d   = PAUSE;
          pg_stop_c = 1'b1;
          if (saturate) ovf_d = 1'b1;
        end else if (ev_lap) begin
          if (state_q == RUN) begin
            // Freeze the pre-tick counter values of this cycle.
            state_d   = LAP;
            lap_min_d = min_q;
            lap_sec_d = sec_q;
            lap_ms_d  = ms_q;
          end else begin
            state_d = RUN;
          end
        end
      end
      PAUSE: begin
        if (ev_clear) begin
          state_d    = IDLE;
          min_d      = '0;
          sec_d      = '0;
          ms_d       = '0;
          ovf_d      = 1'b0;
          pg_reset_c = 1'b1;
        end else if (ev_start && !ovf_q) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, lap snapshot and registered generator enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      min_q      <= '0;
      sec_q      <= '0;
      ms_q       <= '0;
      lap_min_q  <= '0;
      lap_sec_q  <= '0;
      lap_ms_q   <= '0;
      ovf_q      <= 1'b0;
      pg_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      ms_q       <= ms_d;
      lap_min_q  <= lap_min_d;
      lap_sec_q  <= lap_sec_d;
      lap_ms_q   <= lap_ms_d;
      ovf_q      <= ovf_d;
      pg_start_q <= (state_d == RUN) || (state_d == LAP);
    end
  end

  // Pulses are suppressed during reset so reset never emits stop/reset commands.
  assign pg_stop    = pg_stop_c  & ~reset;
  assign pg_reset   = pg_reset_c & ~reset;
  assign pg_start   = pg_start_q;
  assign running    = counting;
  assign lap_frozen = (state_q == LAP);
  assign ovf        = ovf_q;
  assign disp_min   = lap_frozen ? lap_min_q : min_q;
  assign disp_sec   = lap_frozen ? lap_sec_q : sec_q;
  assign disp_ms    = lap_frozen ? lap_ms_q  : ms_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM and time accumulator for the stopwatch. Edge-detects the start/stop/clear/lap buttons and sequences the millisecond pulse generator through its start, stop and reset inputs. Counts that generator's msclock ticks into min/sec/ms counters and drives a display bus that can be frozen for lap times. Sits between the button synchronisers and the display encoder.

Parameters:
MAX_MIN, 100, minute counter modulus; minutes count 0..MAX_MIN-1.
MIN_W, 7, width of the minute counter; must satisfy 2**MIN_W >= MAX_MIN.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high; all state is cleared on the clk edge where reset=1.
btn_start  in  1  synchronised start button level.
btn_stop  in  1  synchronised stop button level.
btn_clear  in  1  synchronised clear button level.
btn_lap  in  1  synchronised lap button level.
msclock  in  1  tick from the ms pulse generator; each rising edge is one millisecond.
pg_start  out  1  level; enables the pulse generator.
pg_stop  out  1  one-cycle pulse; halts the pulse generator.
pg_reset  out  1  one-cycle pulse; resets the pulse generator phase.
disp_min  out  MIN_W  displayed minutes.
disp_sec  out  6  displayed seconds, 0..59.
disp_ms  out  10  displayed milliseconds, 0..999.
running  out  1  high in RUN and LAP.
lap_frozen  out  1  high in LAP.
ovf  out  1  sticky; high once saturation is reached.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, edge-detect history registers 0.
- Buttons: an event is a rising edge, i.e. the current level is 1 and the previous-cycle level is 0. A held button produces one event only.
- msclock: an internal tick is the rising edge of msclock. A multi-cycle-high msclock counts once.
- States: IDLE, RUN, PAUSE, LAP.
- Event priority when several events occur in one cycle: clear > stop > start > lap.
- IDLE:
  - start -> RUN; pg_reset pulses the same cycle.
  - All other events are ignored.
- RUN:
  - stop -> PAUSE; pg_stop pulses.
  - lap -> LAP; the display is latched from the counter values of that cycle.
  - clear -> IDLE; counters zeroed; pg_reset pulses.
- LAP:
  - Counting continues; display outputs hold the latched value.
  - lap -> RUN; the display tracks the live counters again.
  - stop -> PAUSE; the display shows the live counters.
  - clear -> IDLE.
- PAUSE:
  - start -> RUN, resuming from the held count; no pg_reset.
  - clear -> IDLE.
  - lap is ignored.
- pg_start = 1 in RUN and LAP, 0 otherwise. It is a registered output.
- Counting: a tick is counted only if the registered state is RUN or LAP in that cycle. A tick in the same cycle as a stop event is therefore counted.
- Rollover: ms 999 -> 0 and sec+1; sec 59 -> 0 and min+1; all in one cycle.
- Saturation: a tick at MAX_MIN-1:59:999 is not counted. Instead, ovf is set to 1, state -> PAUSE and pg_stop pulses.
  - ovf clears only on clear or reset.
  - start in PAUSE with ovf=1 is ignored.
- Display: when not in LAP, disp_* equal the counter registers, with one cycle of latency after a counted tick.
- Reset mid-operation: the next cycle is IDLE with all outputs 0. No pg_stop or pg_reset pulse is emitted because of reset.

Decomposition:
- Package stopwatch_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, LAP);
  - the constants MS_MAX=999, SEC_MAX=59, and the widths 10 and 6.
- One sub-module, edge_detect: a 1-bit rising-edge detector with synchronous reset. It is instantiated five times: four buttons and msclock.

Test Plan:
- Reset, then a start edge, then 1500 msclock rising edges -> disp = 0:01:500; running=1; pg_reset pulses exactly once, at start.
- While running at 0:00:010, hold btn_stop high for 20 cycles with 5 ticks -> one pg_stop pulse; the count freezes at the value including any tick coincident with stop. A later start edge resumes without pg_reset.
- Lap at 0:02:000, then 3000 more ticks -> disp stays 0:02:000 with lap_frozen=1. A second lap edge -> disp shows 0:05:000.
- Preload by ticking to MAX_MIN-1:59:999, then one more tick -> count holds; ovf=1; state PAUSE; pg_stop pulses. A start edge has no effect; clear -> all 0 and ovf=0.
- Assert start, stop and clear edges in the same cycle while in RUN -> IDLE with counters 0 (clear wins). Asserting reset during RUN -> all outputs 0 next cycle.
- Hold msclock high for 4 cycles -> exactly 1 ms is counted. A lap edge in IDLE or PAUSE -> no state change.
